mdu_issue_ctrl: RTL and testbench
=================================

// Module: mdu_issue_ctrl
// PURPOSE
//  Requester side of the multiply/divide unit. Decodes MIPS SPECIAL md ops in E, issues start/op to the MD unit,
//  mirrors its busy window with a latency countdown, and raises stall_md so mult/div/mfhi/mflo/mthi/mtlo in D
//  wait until HI/LO are settled. Sits between the D/E pipeline registers and the hazard unit.
// PARAMETERS
//  MUL_LAT   5    busy cycles after a mult/multu start
//  DIV_LAT   10   busy cycles after a div/divu start
//  CNT_W     16   width of saturating stall-cycle performance counter
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      synchronous, active-high
//  instrD       in   32     instruction in decode
//  instrE       in   32     instruction in execute
//  flushE       in   1      1 = instrE is a bubble this cycle (treated as nop)
//  md_start     out  1      1-cycle pulse: start mult/div in the MD unit
//  md_op        out  2      0 mult,1 multu,2 div,3 divu; valid with md_start
//  hilo_we      out  1      mthi/mtlo in E: write HI/LO this cycle
//  hilo_sel     out  1      0 LO,1 HI; for mthi/mtlo write and mfhi/mflo read in E
//  busy         out  1      MD result not yet available
//  stall_md     out  1      stall D (to hazard unit)
//  stall_cnt    out  CNT_W  cycles stall_md was 1 since reset, saturating
// BEHAVIOUR
//  Decode: md op iff instr[31:26]==0 and funct=instr[5:0] in {18 mult,19 multu,1a div,1b divu,
//   10 mfhi,11 mthi,12 mflo,13 mtlo}; anything else (incl. instr==0) is not md.
//  startE = ~flushE & instrE is mult/multu/div/divu. md_start = startE (combinational, same cycle),
//   md_op = funct[1:0]. Outputs 0 when not startE.
//  hilo_we = ~flushE & instrE in {mthi,mtlo}; hilo_sel = funct[1] ? 0 : 1 for mf/mt (10/11->HI, 12/13->LO); 0 otherwise.
//  State: IDLE / BUSY, register cnt (width ceil(log2(DIV_LAT+1))).
//   IDLE: startE -> BUSY, cnt<=MUL_LAT (funct[1]==0) or DIV_LAT (funct[1]==1).
//   BUSY: cnt<=cnt-1 each cycle; when cnt==1 -> IDLE, cnt<=0 on the same edge.
//   BUSY & startE (only possible after flush/abnormal issue): restart, cnt reloaded per new op; no error flag.
//  busy = (state==BUSY) | startE (combinational; covers the start cycle itself).
//  stall_md = busy & instrD is any md op (incl. mthi/mtlo). Non-md instrD never stalled by this block.
//  So mult in E at cycle t: busy during t..t+MUL_LAT, first unstalled mflo in D at t+MUL_LAT+1.
//  stall_cnt: +1 per cycle stall_md==1, holds at 2^CNT_W-1 (no wrap).
//  Divide by zero: no special case; full DIV_LAT busy window (HI/LO value is the MD unit's concern).
//  Reset (any time, incl. mid-BUSY): state<=IDLE, cnt<=0, stall_cnt<=0; registered outputs 0 next cycle;
//   combinational outputs follow inputs (md_start can pulse on the reset cycle if instrE is a start;
//   busy window is NOT armed by that start).
//  Reset values after clearing with instrE=instrD=0: md_start=0, md_op=0, hilo_we=0, hilo_sel=0,
//   busy=0, stall_md=0, stall_cnt=0.
// TESTING
//  T1 instrE=00a60018 (mult) 1 cycle, then 0; instrD=00001012 (mflo) held -> md_start=1 md_op=0 at t;
//     stall_md=1 for cycles t..t+5 (6 cycles), 0 at t+6; stall_cnt=6.
//  T2 instrE=00a6001b (divu) -> md_op=3; instrD=00001810 (mfhi) stalled t..t+10, released t+11; stall_cnt=11.
//  T3 instrE=00a60019 then instrD=00a6001a (div) queued behind it -> div stalled 6 cycles; when it enters E,
//     md_start=1 md_op=2, new 11-cycle busy window; instrD=add (00a61020) during busy -> stall_md=0.
//  T4 div started, reset=1 at t+3 for 1 cycle -> busy=0 and stall_md=0 from t+4, stall_cnt=0;
//     instrE=00a60018 with flushE=1 -> md_start=0, busy stays 0.
//  T5 instrE=00400011 (mthi $2) -> hilo_we=1 hilo_sel=1; 00400013 (mtlo) -> hilo_we=1 hilo_sel=0; no busy.
//  T6 CNT_W=4, hold instrD=mflo across repeated mult issues -> stall_cnt saturates at 15, never wraps.

Source files
------------

// File: rtl/mdu_issue_ctrl.sv
// Requester side of the multiply/divide unit: decodes md ops in E, issues start/op,
// tracks the MD busy window and stalls md-type instructions waiting in D.
module mdu_issue_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instrD,
    input  logic [31:0]      instrE,
    input  logic             flushE,
    output logic             md_start,
    output logic [1:0]       md_op,
    output logic             hilo_we,
    output logic             hilo_sel,
    output logic             busy,
    output logic             stall_md,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int CW = $clog2(DIV_LAT + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_r, state_n_s;
    logic [CW-1:0]   cnt_r, cnt_n_s;
    logic [CNT_W-1:0] stall_cnt_r;

    function automatic logic is_md(input logic [5:0] opc, input logic [5:0] funct);
        case (funct)
            6'h10, 6'h11, 6'h12, 6'h13,
            6'h18, 6'h19, 6'h1a, 6'h1b: is_md = (opc == 6'd0);
            default:                    is_md = 1'b0;
        endcase
    endfunction

    function automatic logic is_start(input logic [5:0] opc, input logic [5:0] funct);
        case (funct)
            6'h18, 6'h19, 6'h1a, 6'h1b: is_start = (opc == 6'd0);
            default:                    is_start = 1'b0;
        endcase
    endfunction

    function automatic logic is_mfmt(input logic [5:0] opc, input logic [5:0] funct);
        case (funct)
            6'h10, 6'h11, 6'h12, 6'h13: is_mfmt = (opc == 6'd0);
            default:                    is_mfmt = 1'b0;
        endcase
    endfunction

    logic [5:0] opc_e_s, funct_e_s;
    logic       start_e_s, mfmt_e_s, mt_e_s, md_d_s;
    logic [CW-1:0] lat_s;
    logic       unused_s;

    assign opc_e_s   = instrE[31:26];
    assign funct_e_s = instrE[5:0];
    assign start_e_s = ~flushE & is_start(opc_e_s, funct_e_s);
    assign mfmt_e_s  = ~flushE & is_mfmt(opc_e_s, funct_e_s);
    // mthi (11) and mtlo (13) are the mf/mt codes with funct[0] set
    assign mt_e_s    = mfmt_e_s & funct_e_s[0];
    assign md_d_s    = is_md(instrD[31:26], instrD[5:0]);
    assign lat_s     = funct_e_s[1] ? CW'(DIV_LAT) : CW'(MUL_LAT);
    assign unused_s  = ^{instrD[25:6], instrE[25:6]};

    assign md_start  = start_e_s;
    assign md_op     = start_e_s ? funct_e_s[1:0] : 2'b00;
    assign hilo_we   = mt_e_s;
    assign hilo_sel  = mfmt_e_s & ~funct_e_s[1];
    assign busy      = (state_r == BUSY) | start_e_s;
    assign stall_md  = busy & md_d_s;
    assign stall_cnt = stall_cnt_r;

    // Next-state and countdown for the busy window; a start always (re)loads the latency
    always_comb begin
        state_n_s = state_r;
        cnt_n_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (start_e_s) begin
                    state_n_s = BUSY;
                    cnt_n_s   = lat_s;
                end else begin
                    state_n_s = IDLE;
                    cnt_n_s   = {CW{1'b0}};
                end
            end
            BUSY: begin
                if (start_e_s) begin
                    state_n_s = BUSY;
                    cnt_n_s   = lat_s;
                end else if (cnt_r == CW'(1)) begin
                    state_n_s = IDLE;
                    cnt_n_s   = {CW{1'b0}};
                end else begin
                    state_n_s = BUSY;
                    cnt_n_s   = cnt_r - CW'(1);
                end
            end
            default: begin
                state_n_s = IDLE;
                cnt_n_s   = {CW{1'b0}};
            end
        endcase
    end

    // State, countdown and saturating stall counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            stall_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
            if (stall_md && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end
endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl: a per-cycle vector table plus hand sequences
// for chained issue, mid-busy reset, restart and counter saturation.
module tb_mdu_issue_ctrl;
    localparam logic [31:0] MULT  = 32'h00a60018;
    localparam logic [31:0] MULTU = 32'h00a60019;
    localparam logic [31:0] DIV   = 32'h00a6001a;
    localparam logic [31:0] DIVU  = 32'h00a6001b;
    localparam logic [31:0] MFHI  = 32'h00001810;
    localparam logic [31:0] MFLO  = 32'h00001012;
    localparam logic [31:0] MTHI  = 32'h00400011;
    localparam logic [31:0] MTLO  = 32'h00400013;
    localparam logic [31:0] ADD   = 32'h00a61020;
    localparam logic [31:0] NOP   = 32'h00000000;

    logic        clk;
    logic        reset;
    logic [31:0] instrD, instrE;
    logic        flushE;
    logic        md_start, hilo_we, hilo_sel, busy, stall_md;
    logic [1:0]  md_op;
    logic [15:0] stall_cnt;
    logic        s_md_start, s_hilo_we, s_hilo_sel, s_busy, s_stall_md;
    logic [1:0]  s_md_op;
    logic [3:0]  s_stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    mdu_issue_ctrl dut (
        .clk(clk), .reset(reset), .instrD(instrD), .instrE(instrE), .flushE(flushE),
        .md_start(md_start), .md_op(md_op), .hilo_we(hilo_we), .hilo_sel(hilo_sel),
        .busy(busy), .stall_md(stall_md), .stall_cnt(stall_cnt)
    );

    mdu_issue_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .instrD(instrD), .instrE(instrE), .flushE(flushE),
        .md_start(s_md_start), .md_op(s_md_op), .hilo_we(s_hilo_we), .hilo_sel(s_hilo_sel),
        .busy(s_busy), .stall_md(s_stall_md), .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [31:0] e;
        logic        f;
        logic        r;
        logic        st;
        logic [1:0]  op;
        logic        we;
        logic        sel;
        logic        bsy;
        logic        stl;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic push(input logic [31:0] d, input logic [31:0] e, input logic f, input logic r,
                        input logic st, input logic [1:0] op, input logic we, input logic sel,
                        input logic bsy, input logic stl, input logic [15:0] cnt);
        vec_t v;
        v.d = d; v.e = e; v.f = f; v.r = r; v.st = st; v.op = op; v.we = we;
        v.sel = sel; v.bsy = bsy; v.stl = stl; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs just after a rising edge, then wait to the falling edge for sampling.
    task automatic apply(input logic [31:0] d, input logic [31:0] e, input logic f, input logic r);
        instrD = d; instrE = e; flushE = f; reset = r;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply(NOP, NOP, 1'b0, 1'b1);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        instrD = NOP; instrE = NOP; flushE = 1'b0; reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state, T1 (mult / mflo)
        push(NOP, NOP, 0, 0, 0, 2'd0, 0, 0, 0, 0, 16'd0);
        push(MFLO, MULT, 0, 0, 1, 2'd0, 0, 0, 1, 1, 16'd0);
        for (int k = 1; k <= 5; k++) push(MFLO, NOP, 0, 0, 0, 2'd0, 0, 0, 1, 1, 16'(k));
        push(MFLO, NOP, 0, 0, 0, 2'd0, 0, 0, 0, 0, 16'd6);
        // T5 and decode corners
        push(NOP, MTHI, 0, 0, 0, 2'd0, 1, 1, 0, 0, 16'd6);
        push(NOP, MTLO, 0, 0, 0, 2'd0, 1, 0, 0, 0, 16'd6);
        push(NOP, MFHI, 0, 0, 0, 2'd0, 0, 1, 0, 0, 16'd6);
        push(NOP, MFLO, 0, 0, 0, 2'd0, 0, 0, 0, 0, 16'd6);
        push(MFLO, ADD, 0, 0, 0, 2'd0, 0, 0, 0, 0, 16'd6);
        push(MFLO, MULT, 1, 0, 0, 2'd0, 0, 0, 0, 0, 16'd6);
        push(32'h20001012, 32'h20a60018, 0, 0, 0, 2'd0, 0, 0, 0, 0, 16'd6);
        // T2 (divu / mfhi) from a fresh reset
        push(NOP, NOP, 0, 1, 0, 2'd0, 0, 0, 0, 0, 16'd6);
        push(MFHI, DIVU, 0, 0, 1, 2'd3, 0, 0, 1, 1, 16'd0);
        for (int k = 1; k <= 10; k++) push(MFHI, NOP, 0, 0, 0, 2'd0, 0, 0, 1, 1, 16'(k));
        push(MFHI, NOP, 0, 0, 0, 2'd0, 0, 0, 0, 0, 16'd11);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].d, tbl[i].e, tbl[i].f, tbl[i].r);
            chk($sformatf("v%0d md_start", i), {31'd0, md_start}, {31'd0, tbl[i].st});
            chk($sformatf("v%0d md_op", i), {30'd0, md_op}, {30'd0, tbl[i].op});
            chk($sformatf("v%0d hilo_we", i), {31'd0, hilo_we}, {31'd0, tbl[i].we});
            chk($sformatf("v%0d hilo_sel", i), {31'd0, hilo_sel}, {31'd0, tbl[i].sel});
            chk($sformatf("v%0d busy", i), {31'd0, busy}, {31'd0, tbl[i].bsy});
            chk($sformatf("v%0d stall_md", i), {31'd0, stall_md}, {31'd0, tbl[i].stl});
            chk($sformatf("v%0d stall_cnt", i), {16'd0, stall_cnt}, {16'd0, tbl[i].cnt});
            tick();
        end

        // T3: multu in E, div queued in D, then add during the div window
        do_reset();
        apply(DIV, MULTU, 1'b0, 1'b0);
        chk("t3 start multu", {30'd0, md_start, 1'b0} | {30'd0, md_op}, 32'd3);
        chk("t3 stall t", {31'd0, stall_md}, 32'd1);
        tick();
        for (int k = 1; k <= 5; k++) begin
            apply(DIV, NOP, 1'b0, 1'b0);
            chk($sformatf("t3 stall t+%0d", k), {31'd0, stall_md}, 32'd1);
            tick();
        end
        apply(DIV, NOP, 1'b0, 1'b0);
        chk("t3 release stall", {31'd0, stall_md}, 32'd0);
        chk("t3 release busy", {31'd0, busy}, 32'd0);
        chk("t3 stall_cnt", {16'd0, stall_cnt}, 32'd6);
        tick();
        apply(ADD, DIV, 1'b0, 1'b0);
        chk("t3 div start", {31'd0, md_start}, 32'd1);
        chk("t3 div op", {30'd0, md_op}, 32'd2);
        chk("t3 add stall", {31'd0, stall_md}, 32'd0);
        tick();
        for (int k = 1; k <= 10; k++) begin
            apply(ADD, NOP, 1'b0, 1'b0);
            chk($sformatf("t3 div busy +%0d", k), {30'd0, busy, stall_md}, 32'd2);
            tick();
        end
        apply(ADD, NOP, 1'b0, 1'b0);
        chk("t3 div busy end", {31'd0, busy}, 32'd0);
        tick();

        // T4: reset mid-divide, then a flushed mult
        do_reset();
        apply(MFLO, DIV, 1'b0, 1'b0);
        chk("t4 div busy", {31'd0, busy}, 32'd1);
        tick();
        for (int k = 1; k <= 2; k++) begin
            apply(MFLO, NOP, 1'b0, 1'b0);
            tick();
        end
        apply(MFLO, NOP, 1'b0, 1'b1);
        chk("t4 busy in reset cycle", {31'd0, busy}, 32'd1);
        tick();
        apply(MFLO, NOP, 1'b0, 1'b0);
        chk("t4 busy after reset", {31'd0, busy}, 32'd0);
        chk("t4 stall after reset", {31'd0, stall_md}, 32'd0);
        chk("t4 cnt after reset", {16'd0, stall_cnt}, 32'd0);
        tick();
        apply(MFLO, MULT, 1'b1, 1'b0);
        chk("t4 flushed start", {31'd0, md_start}, 32'd0);
        chk("t4 flushed busy", {31'd0, busy}, 32'd0);
        tick();
        apply(MFLO, NOP, 1'b0, 1'b0);
        chk("t4 flushed busy next", {31'd0, busy}, 32'd0);
        tick();

        // Restart while busy: div issued two cycles into a mult window reloads DIV_LAT
        do_reset();
        apply(NOP, MULT, 1'b0, 1'b0);
        tick();
        apply(NOP, NOP, 1'b0, 1'b0);
        tick();
        apply(NOP, DIV, 1'b0, 1'b0);
        chk("rs start", {30'd0, md_op}, 32'd2);
        tick();
        for (int k = 1; k <= 10; k++) begin
            apply(NOP, NOP, 1'b0, 1'b0);
            chk($sformatf("rs busy +%0d", k), {31'd0, busy}, 32'd1);
            tick();
        end
        apply(NOP, NOP, 1'b0, 1'b0);
        chk("rs idle", {31'd0, busy}, 32'd0);
        tick();

        // T6: back-to-back mults with mflo held; 4-bit counter saturates at 15
        do_reset();
        for (int k = 0; k < 20; k++) begin
            apply(MFLO, (k % 6 == 0) ? MULT : NOP, 1'b0, 1'b0);
            chk($sformatf("t6 stall %0d", k), {31'd0, stall_md}, 32'd1);
            chk($sformatf("t6 cnt16 %0d", k), {16'd0, stall_cnt}, 32'(k));
            chk($sformatf("t6 cnt4 %0d", k), {28'd0, s_stall_cnt}, (k > 15) ? 32'd15 : 32'(k));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
